// File: rtl/radiant_pulse_gen_pkg.sv
// Shared definitions for the calibration pulse generator: mode codes, register map,
// CTRL/STATUS bit positions, FSM states and the WISHBONE byte-select expander.
package radiant_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeCont  = 2'd1,
        ModeBurst = 2'd2,
        ModeExt   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } state_e;

    // Register index taken from wb_adr_i[3:2]
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPeriod = 2'd1;
    localparam logic [1:0] RegWidth  = 2'd2;
    localparam logic [1:0] RegBurst  = 2'd3;

    localparam int unsigned CtrlStartBit  = 2;
    localparam int unsigned CtrlDoneBit   = 3;
    localparam int unsigned CtrlMaskLsb   = 8;
    localparam int unsigned StatMissedLsb = 16;
    localparam int unsigned StatBusyBit   = 24;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/radiant_pulse_gen_core.sv
// Pulse sequencer: IDLE/HIGH/LOW state machine with period/width shadow registers,
// cycle counter and burst down-counter.
module radiant_pulse_gen_core
    import radiant_pulse_gen_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = 24,
    parameter int unsigned BURST_BITS  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  mode_e                  mode_i,
    input  logic                   start_i,
    input  logic                   trig_i,
    input  logic [PERIOD_BITS-1:0] period_i,
    input  logic [PERIOD_BITS-1:0] width_i,
    input  logic [BURST_BITS-1:0]  burst_i,
    output logic                   high_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [BURST_BITS-1:0]  remaining_o
);

    localparam logic [PERIOD_BITS-1:0] MinPeriod = PERIOD_BITS'(2);
    localparam logic [PERIOD_BITS-1:0] CntOne    = PERIOD_BITS'(1);
    localparam logic [BURST_BITS-1:0]  BurstOne  = BURST_BITS'(1);

    state_e                 state_q, state_d;
    mode_e                  run_mode_q, run_mode_d;
    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic [PERIOD_BITS-1:0] p_q, p_d;
    logic [PERIOD_BITS-1:0] w_q, w_d;
    logic [PERIOD_BITS-1:0] p_new, w_new;
    logic [BURST_BITS-1:0]  rem_q, rem_d;
    logic                   launch, period_start, period_end, abort;

    always_comb begin
        p_new = (period_i < MinPeriod) ? MinPeriod : period_i;
        w_new = (width_i > p_new) ? p_new : width_i;
    end

    // Any mode change while running cancels the sequence without flagging done
    assign abort = (state_q != StIdle) && (mode_i != run_mode_q);

    always_comb begin
        state_d      = state_q;
        run_mode_d   = run_mode_q;
        cnt_d        = cnt_q;
        p_d          = p_q;
        w_d          = w_q;
        rem_d        = rem_q;
        done_o       = 1'b0;
        launch       = 1'b0;
        period_start = 1'b0;
        period_end   = 1'b0;

        unique case (state_q)
            StIdle: begin
                launch = (mode_i == ModeCont) ||
                         ((mode_i == ModeBurst) && start_i) ||
                         ((mode_i == ModeExt) && trig_i);
                if (launch) begin
                    run_mode_d   = mode_i;
                    rem_d        = (burst_i == '0) ? BurstOne : burst_i;
                    period_start = 1'b1;
                end
            end
            StHigh: begin
                if (cnt_q == '0) begin
                    if (w_q == p_q) begin
                        period_end = 1'b1;
                    end else begin
                        state_d = StLow;
                        cnt_d   = p_q - w_q - CntOne;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StLow: begin
                if (cnt_q == '0) begin
                    period_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase

        if (period_end) begin
            if (run_mode_q == ModeCont) begin
                period_start = 1'b1;
            end else if (rem_q <= BurstOne) begin
                rem_d   = '0;
                state_d = StIdle;
                done_o  = 1'b1;
            end else begin
                rem_d        = rem_q - BurstOne;
                period_start = 1'b1;
            end
        end

        // Shadow the programmed timing once per period; w=0 goes straight to LOW
        if (period_start) begin
            p_d = p_new;
            w_d = w_new;
            if (w_new == '0) begin
                state_d = StLow;
                cnt_d   = p_new - CntOne;
            end else begin
                state_d = StHigh;
                cnt_d   = w_new - CntOne;
            end
        end

        if (abort) begin
            state_d = StIdle;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            run_mode_q <= ModeOff;
            cnt_q      <= '0;
            p_q        <= '0;
            w_q        <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            run_mode_q <= run_mode_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            w_q        <= w_d;
            rem_q      <= rem_d;
        end
    end

    assign high_o      = (state_q == StHigh) && !abort;
    assign busy_o      = (state_q != StIdle);
    assign remaining_o = rem_q;

endmodule

// File: rtl/radiant_pulse_gen.sv
// Multi-channel calibration pulse generator: WISHBONE register file, trigger edge detect,
// missed-trigger counter and registered per-channel mask/polarity outputs.
module radiant_pulse_gen
    import radiant_pulse_gen_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 1,
    parameter int unsigned       PERIOD_BITS = 24,
    parameter int unsigned       BURST_BITS  = 16,
    parameter logic [NUM_CH-1:0] POLARITY    = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    input  logic              trig_i,
    output logic [NUM_CH-1:0] pulse_o,
    output logic              busy_o
);

    logic                   ack_q;
    logic [31:0]            rdata_q, rdata;
    mode_e                  mode_q;
    logic                   done_q, start_q, trig_q;
    logic [NUM_CH-1:0]      mask_q, pulse_q, mask_wr;
    logic [PERIOD_BITS-1:0] period_q, width_q, period_wr, width_wr;
    logic [BURST_BITS-1:0]  burst_q, burst_wr;
    logic [7:0]             missed_q;
    logic [1:0]             mode_wr;
    logic [31:0]            bmask, ctrl_rd, status_rd;
    logic                   req, wr, wr_ctrl, wr_period, wr_width, wr_burst, trig_edge;
    logic                   core_high, core_busy, core_done;
    logic [BURST_BITS-1:0]  core_rem;
    logic                   unused_bits;

    assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr        = req & wb_we_i;
    assign wr_ctrl   = wr && (wb_adr_i[3:2] == RegCtrl);
    assign wr_period = wr && (wb_adr_i[3:2] == RegPeriod);
    assign wr_width  = wr && (wb_adr_i[3:2] == RegWidth);
    assign wr_burst  = wr && (wb_adr_i[3:2] == RegBurst);
    assign bmask     = byte_mask(wb_sel_i);
    assign trig_edge = trig_i & ~trig_q;

    // Byte-lane merges of write data into the current register contents
    assign mode_wr   = (mode_q & ~bmask[1:0]) | (wb_dat_i[1:0] & bmask[1:0]);
    assign mask_wr   = (mask_q & ~bmask[CtrlMaskLsb +: NUM_CH]) |
                       (wb_dat_i[CtrlMaskLsb +: NUM_CH] & bmask[CtrlMaskLsb +: NUM_CH]);
    assign period_wr = (period_q & ~bmask[PERIOD_BITS-1:0]) |
                       (wb_dat_i[PERIOD_BITS-1:0] & bmask[PERIOD_BITS-1:0]);
    assign width_wr  = (width_q & ~bmask[PERIOD_BITS-1:0]) |
                       (wb_dat_i[PERIOD_BITS-1:0] & bmask[PERIOD_BITS-1:0]);
    assign burst_wr  = (burst_q & ~bmask[BURST_BITS-1:0]) |
                       (wb_dat_i[BURST_BITS-1:0] & bmask[BURST_BITS-1:0]);

    assign unused_bits = ^{wb_adr_i[1:0], bmask, wb_dat_i};

    always_comb begin
        ctrl_rd                          = '0;
        ctrl_rd[1:0]                     = mode_q;
        ctrl_rd[CtrlDoneBit]             = done_q;
        ctrl_rd[CtrlMaskLsb +: NUM_CH]   = mask_q;
        status_rd                        = '0;
        status_rd[15:0]                  = 16'(core_rem);
        status_rd[StatMissedLsb +: 8]    = missed_q;
        status_rd[StatBusyBit]           = core_busy;
        unique case (wb_adr_i[3:2])
            RegCtrl:   rdata = ctrl_rd;
            RegPeriod: rdata = 32'(period_q);
            RegWidth:  rdata = 32'(width_q);
            RegBurst:  rdata = status_rd;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            mode_q   <= ModeOff;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            trig_q   <= 1'b0;
            mask_q   <= '0;
            period_q <= '0;
            width_q  <= '0;
            burst_q  <= '0;
            missed_q <= '0;
            pulse_q  <= POLARITY;
        end else begin
            ack_q   <= req;
            start_q <= wr_ctrl & bmask[CtrlStartBit] & wb_dat_i[CtrlStartBit];
            trig_q  <= trig_i;
            if (req && !wb_we_i) begin
                rdata_q <= rdata;
            end
            if (wr_ctrl) begin
                mode_q <= mode_e'(mode_wr);
                mask_q <= mask_wr;
            end
            if (core_done) begin
                done_q <= 1'b1;
            end else if (wr_ctrl && bmask[CtrlDoneBit] && wb_dat_i[CtrlDoneBit]) begin
                done_q <= 1'b0;
            end
            if (wr_period) begin
                period_q <= period_wr;
            end
            if (wr_width) begin
                width_q <= width_wr;
            end
            if (wr_burst) begin
                burst_q  <= burst_wr;
                missed_q <= '0;
            end else if ((mode_q == ModeExt) && trig_edge && core_busy &&
                         (missed_q != 8'hFF)) begin
                missed_q <= missed_q + 8'd1;
            end
            pulse_q <= ({NUM_CH{core_high}} & mask_q) ^ POLARITY;
        end
    end

    radiant_pulse_gen_core #(
        .PERIOD_BITS (PERIOD_BITS),
        .BURST_BITS  (BURST_BITS)
    ) u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mode_i      (mode_q),
        .start_i     (start_q),
        .trig_i      (trig_edge),
        .period_i    (period_q),
        .width_i     (width_q),
        .burst_i     (burst_q),
        .high_o      (core_high),
        .busy_o      (core_busy),
        .done_o      (core_done),
        .remaining_o (core_rem)
    );

    assign wb_dat_o = rdata_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign pulse_o  = pulse_q;
    assign busy_o   = core_busy;

endmodule

// File: tb/tb_radiant_pulse_gen.sv
// Directed bench for radiant_pulse_gen: two channels, channel 1 idle-high and masked off.
module tb_radiant_pulse_gen;

    localparam logic [1:0] Pol = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic        trig_i = 1'b0;
    logic [1:0]  pulse_o;
    logic        busy_o;

    int total = 0;
    int bad = 0;

    radiant_pulse_gen #(
        .NUM_CH      (2),
        .PERIOD_BITS (24),
        .BURST_BITS  (16),
        .POLARITY    (Pol)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .trig_i   (trig_i),
        .pulse_o  (pulse_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pulse(input bit hi);
        logic [1:0] v;
        v = Pol ^ {1'b0, hi};
        return {30'd0, v};
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Called at a falling edge; returns at the falling edge where ack is seen
    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdata);
        bit got;
        got = 1'b0;
        rdata = '0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk_i);
            if (wb_ack_o === 1'b1) begin
                got = 1'b1;
                rdata = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check("wb_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, dat, dummy);
    endtask

    task automatic rd(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, adr, 32'd0, d);
        check(tag, d, exp);
    endtask

    initial begin
        bit   hi;
        int   n, nb, nh;
        logic prev;

        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_pulse", {30'd0, pulse_o}, {30'd0, Pol});
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rd("rst_ctrl", 4'd0, 32'd0);
        rd("rst_period", 4'd4, 32'd0);
        rd("rst_width", 4'd8, 32'd0);
        rd("rst_status", 4'd12, 32'd0);

        // Continuous: 3 high / 7 low, first active sample two cycles after ack
        wr(4'd4, 32'd10);
        wr(4'd8, 32'd3);
        wr(4'd0, 32'h101);
        for (int c = 0; c <= 20; c++) begin
            hi = (c >= 2) && (((c - 2) % 10) < 3);
            check("cont_pulse", {30'd0, pulse_o}, exp_pulse(hi));
            if (c == 5) check("cont_busy", {31'd0, busy_o}, 32'd1);
            tick();
        end
        // Width rewritten mid-HIGH: current pulse keeps 3, next pulse is 5
        wr(4'd8, 32'd5);
        for (int c = 22; c <= 41; c++) begin
            hi = (c >= 22 && c <= 24) || (c >= 32 && c <= 36);
            check("width_change", {30'd0, pulse_o}, exp_pulse(hi));
            tick();
        end
        check("pre_off_pulse", {30'd0, pulse_o}, exp_pulse(1'b1));
        wr(4'd0, 32'h100);
        tick();
        check("off_pulse", {30'd0, pulse_o}, exp_pulse(1'b0));
        check("off_busy", {31'd0, busy_o}, 32'd0);
        rd("off_ctrl", 4'd0, 32'h100);

        // SW burst of 4 with mode and start in the same write
        wr(4'd8, 32'd3);
        wr(4'd12, 32'd4);
        wr(4'd0, 32'h106);
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) check("burst_busy", {31'd0, busy_o}, 32'd1);
            if (pulse_o[0] && !prev) n++;
            prev = pulse_o[0];
            tick();
        end
        check("burst_pulses", 32'(n), 32'd4);
        check("burst_idle", {31'd0, busy_o}, 32'd0);
        rd("burst_ctrl", 4'd0, 32'h10A);
        rd("burst_status", 4'd12, 32'd0);
        wr(4'd0, 32'h10A);
        rd("done_w1c", 4'd0, 32'h102);

        // External trigger burst of 2, second trigger lands while busy
        wr(4'd12, 32'd2);
        wr(4'd0, 32'h103);
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            trig_i = (c == 0) || (c == 5);
            if (pulse_o[0] && !prev) n++;
            prev = pulse_o[0];
            tick();
        end
        trig_i = 1'b0;
        check("ext_pulses", 32'(n), 32'd2);
        rd("ext_status", 4'd12, 32'h0001_0000);
        rd("ext_ctrl", 4'd0, 32'h10B);
        wr(4'd12, 32'd1);
        rd("missed_clr", 4'd12, 32'd0);

        // PERIOD=0, WIDTH=0: no pulse, each period clamped to 2 cycles
        wr(4'd4, 32'd0);
        wr(4'd8, 32'd0);
        wr(4'd12, 32'd3);
        wr(4'd0, 32'h106);
        nb = 0;
        nh = 0;
        for (int c = 0; c < 15; c++) begin
            nb += int'(busy_o);
            nh += int'(pulse_o[0]);
            tick();
        end
        check("clamp_busy", 32'(nb), 32'd6);
        check("clamp_nopulse", 32'(nh), 32'd0);
        // BURST=0 runs a single period
        wr(4'd12, 32'd0);
        wr(4'd0, 32'h106);
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            nb += int'(busy_o);
            tick();
        end
        check("burst0_busy", 32'(nb), 32'd2);

        // WIDTH > PERIOD: solid active output
        wr(4'd4, 32'd8);
        wr(4'd8, 32'd20);
        wr(4'd0, 32'h101);
        for (int c = 0; c <= 21; c++) begin
            check("solid_pulse", {30'd0, pulse_o}, exp_pulse(c >= 2));
            tick();
        end
        // Reset in the middle of the pulse
        rst_i = 1'b1;
        tick();
        check("midrst_pulse", {30'd0, pulse_o}, {30'd0, Pol});
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        rd("midrst_period", 4'd4, 32'd0);
        rd("midrst_ctrl", 4'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
